// File: rtl/pgs_tsmac_apb_master.sv
// Single-outstanding APB3 initiator for the TSMAC host register port.
// A valid/ready command becomes one SETUP/ACCESS transfer; completion is
// reported on a one-cycle response strobe carrying read data and a timeout flag.
// Handshake: a command transfers on a clock edge where cmd_valid and cmd_ready
// are both high; the requester holds the command stable until then.
// rsp_valid has no ready and must be consumed in the cycle it is high.
module pgs_tsmac_apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // Counter sized to hold TIMEOUT; one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] paddr_next;
    logic [DATA_W-1:0] pwdata_next;
    logic              pwrite_next;
    logic              rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_next;
    logic              rsp_err_next;
    logic              cmd_ready_next;
    logic              psel_next;
    logic              penable_next;

    // State, counter and every output are registered; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cmd_ready <= cmd_ready_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            rsp_err   <= rsp_err_next;
            psel      <= psel_next;
            penable   <= penable_next;
            pwrite    <= pwrite_next;
            paddr     <= paddr_next;
            pwdata    <= pwdata_next;
        end
    end

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        paddr_next     = paddr;
        pwdata_next    = pwdata;
        pwrite_next    = pwrite;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;
        rsp_err_next   = rsp_err;

        case (state)
            IDLE: begin
                // cmd_ready is high throughout IDLE, so cmd_valid alone accepts.
                if (cmd_valid) begin
                    paddr_next  = cmd_addr;
                    pwdata_next = cmd_wdata;
                    pwrite_next = cmd_write;
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                // pready has priority over a timeout landing in the same cycle.
                if (pready) begin
                    rsp_rdata_next = pwrite ? '0 : prdata;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = IDLE;
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cmd_ready_next = (state_next == IDLE);
        psel_next      = (state_next != IDLE);
        penable_next   = (state_next == ACCESS);
    end

endmodule

// File: doc/pgs_tsmac_apb_master.md
# pgs_tsmac_apb_master

Single-outstanding APB3 initiator for the TSMAC host register port. It turns a simple valid/ready command (read or write, address, data) into a compliant SETUP/ACCESS APB transfer with active-high `psel`/`penable`/`pwrite`, waits for `pready` with a bounded timeout, and returns read data plus an error flag on a one-cycle response strobe. It sits between the configuration sequencer or soft-CPU and the APB-to-host adapter in front of the TSMAC core.

## Interface
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 32: APB data width.
- `TIMEOUT`, 255: maximum ACCESS cycles without `pready` before abort. 0 disables the timeout; the block then waits forever. Counter width is `$clog2(TIMEOUT+1)`, minimum 1.
- `clk` in 1: single clock for all logic, including the APB side.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: register address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_rdata` out DATA_W: read data. It is 0 for writes and for timeouts.
- `rsp_err` out 1: 1 = transfer timed out. Qualified by `rsp_valid`.
- `paddr` out ADDR_W: APB address.
- `pwrite` out 1: APB write, active-high.
- `psel` out 1: APB select, active-high.
- `penable` out 1: APB enable, active-high.
- `pwdata` out DATA_W: APB write data.
- `prdata` in DATA_W: APB read data.
- `pready` in 1: APB ready. Sampled only in ACCESS.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered, with no combinational path from any input to any output.
- IDLE:
  - `cmd_ready=1`, `psel=0`, `penable=0`.
  - On accept, latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata` and go to SETUP.
- SETUP:
  - `psel=1`, `penable=0`, `cmd_ready=0`.
  - Unconditionally go to ACCESS; clear the timeout counter.
- ACCESS:
  - `psel=1`, `penable=1`. `paddr`, `pwrite` and `pwdata` are held stable.
  - If `pready=1`: capture `prdata` when `pwrite=0` (0 when `pwrite=1`), set `rsp_err=0`, pulse `rsp_valid`, go to IDLE.
  - If `pready=0` and `TIMEOUT≠0` and the counter equals `TIMEOUT-1`: set `rsp_rdata=0`, `rsp_err=1`, pulse `rsp_valid`, go to IDLE.
  - Otherwise increment the counter and stay in ACCESS.
- `rsp_valid` is high exactly one cycle per accepted command. It has no backpressure; the consumer must take it.
- `rsp_rdata`/`rsp_err` hold their last values until the next completion.
- `paddr`/`pwrite`/`pwdata` keep their last values in IDLE. They are not zeroed.
- Commands presented while `cmd_ready=0` are not accepted. The requester holds them stable.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, counter 0.
- Accept at edge of cycle T: SETUP visible in T+1, ACCESS in T+2.
- With `pready=1` in T+2: `rsp_valid=1` and `psel=penable=0` in T+3. Minimum latency is 3 cycles from accept to response.
- Each wait cycle (`pready=0`) adds one cycle.
- `cmd_ready` returns to 1 in the same cycle as `rsp_valid`. A command accepted then is back-to-back, with its SETUP in the next cycle. Peak throughput is one transfer per 3 cycles.
- Timeout: with `pready` held 0, `rsp_valid` with `rsp_err=1` appears `TIMEOUT+1` cycles after the SETUP cycle.
- A `pready` arriving in the same cycle the timeout would fire wins: the transfer completes normally with `rsp_err=0`.
- `pready` in IDLE/SETUP is ignored.
- Reset asserted mid-transfer: all outputs take reset values asynchronously. No `rsp_valid` is issued for the aborted command, and `psel`/`penable` drop immediately.
- Deassertion of `rst` is synchronized externally. The block is in IDLE on the first clock after release.

## Test plan
- Write with zero wait: `cmd_addr=0x10`, `cmd_wdata=0xA5A5_0001`, `pready=1`. Expect:
  - SETUP in T+1 with `psel=1`, `penable=0`, `pwrite=1`.
  - ACCESS in T+2 with `penable=1`.
  - `rsp_valid=1`, `rsp_err=0`, `rsp_rdata=0` in T+3.
- Read with 3 wait states: `cmd_addr=0x24`; `pready` 0,0,0 then 1 with `prdata=0x1234_5678`. Expect:
  - ACCESS lasts 4 cycles with `paddr` stable.
  - `rsp_rdata=0x1234_5678` in T+6.
- Back-to-back: `cmd_valid` held with write 0x00 then read 0x04, `pready=1`. Expect the second accept in the first response cycle, SETUP the next cycle, and two `rsp_valid` pulses 3 cycles apart.
- Timeout: `TIMEOUT=4`, `pready` tied 0. Expect `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` 5 cycles after SETUP, then `psel=0`. Also apply `pready=1` on exactly the 4th ACCESS cycle and expect `rsp_err=0`.
- Reset mid-ACCESS: assert `rst` asynchronously during a waited read. Expect `psel`, `penable` and `rsp_valid` at 0 without a clock edge, no response after release, and `cmd_ready=1`.
- `cmd_valid` pulsed while busy: present a second command for one cycle during ACCESS. Expect it not accepted and exactly one `rsp_valid`.
